// File: rtl/xbar_pkg.sv
// Shared symbol constants, IDLE ordered-set builder and tx state encoding
// for the crossbar link.
package xbar_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  localparam logic [9:0] D21_4_RDP = 10'h115;
  localparam logic [9:0] D21_4_RDN = 10'h2D5;
  localparam logic [9:0] D21_5     = 10'h155;

  typedef enum logic [1:0] {SYNC, IDLE, DATA, GAP} tx_state_t;

  // Lane 0 (bits [9:0]) carries the comma; the selected polarities leave RD unchanged.
  function automatic logic [39:0] idle_word(input logic rd);
    return rd ? {D21_5, D21_5, D21_4_RDN, K28_5_RDP}
              : {D21_5, D21_5, D21_4_RDP, K28_5_RDN};
  endfunction

endpackage

// File: rtl/xbar_tx_frame_if.sv
// Frame-word input handshake and registered transmit-word outputs.
interface xbar_tx_frame_if;
  logic [39:0] tx_in_data;
  logic        tx_in_valid;
  logic        tx_in_eof;
  logic        tx_in_ready;
  logic [39:0] tx_data;
  logic        tx_rd;
  logic        tx_underrun;
  logic        tx_disp_err;

  modport master (output tx_in_data, tx_in_valid, tx_in_eof,
                  input  tx_in_ready, tx_data, tx_rd, tx_underrun, tx_disp_err);
  modport slave  (input  tx_in_data, tx_in_valid, tx_in_eof,
                  output tx_in_ready, tx_data, tx_rd, tx_underrun, tx_disp_err);
endinterface

// File: rtl/xbar_tx_rd_calc.sv
// Running-disparity step for one 10b symbol: next RD and illegal-disparity flag.
module xbar_tx_rd_calc (
  input  logic [9:0] sym,
  input  logic       rd_in,
  output logic       rd_out,
  output logic       err
);
  logic [3:0] ones;

  assign ones = 4'($countones(sym));

  always_comb begin
    rd_out = rd_in;
    err    = 1'b0;
    case (ones)
      4'd6: begin
        rd_out = 1'b1;
        err    = rd_in;
      end
      4'd4: begin
        rd_out = 1'b0;
        err    = ~rd_in;
      end
      4'd5: ;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/xbar_tx_frame.sv
// Transmit 4x10b word builder: sync burst, IDLE fill, inter-frame gap,
// running-disparity tracking with underrun and disparity-error pulses.
module xbar_tx_frame
  import xbar_pkg::*;
#(
  parameter int SYNC_WORDS = 16,
  parameter int MIN_IDLE   = 6
) (
  input logic             tx_clk,
  input logic             tx_rst,
  xbar_tx_frame_if.slave  bus
);
  localparam int CW = $clog2(((SYNC_WORDS > MIN_IDLE) ? SYNC_WORDS : MIN_IDLE) + 1);

  tx_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [39:0] data_q, data_nxt;
  logic        rd, rd_nxt;
  logic        und_q, und_nxt;
  logic        err_q, err_nxt;
  logic        ready, xfer;
  logic [4:0]  rd_chain;
  logic [3:0]  lane_err;

  // RD ripples through the lanes in wire order, lane 0 first.
  assign rd_chain[0] = rd;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    xbar_tx_rd_calc u_rd (
      .sym    (bus.tx_in_data[i*10 +: 10]),
      .rd_in  (rd_chain[i]),
      .rd_out (rd_chain[i+1]),
      .err    (lane_err[i])
    );
  end

  assign ready = (state == IDLE) || (state == DATA);
  assign xfer  = bus.tx_in_valid & ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = idle_word(rd);
    rd_nxt    = rd;
    und_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      SYNC, GAP: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = IDLE;
      end
      IDLE, DATA: begin
        if (xfer) begin
          data_nxt = bus.tx_in_data;
          rd_nxt   = rd_chain[4];
          err_nxt  = |lane_err;
          if (bus.tx_in_eof) begin
            state_nxt = GAP;
            cnt_nxt   = CW'(MIN_IDLE);
          end else begin
            state_nxt = DATA;
          end
        end else if (state == DATA) begin
          und_nxt = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state  <= SYNC;
      cnt    <= CW'(SYNC_WORDS);
      data_q <= idle_word(1'b0);
      rd     <= 1'b0;
      und_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      rd     <= rd_nxt;
      und_q  <= und_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.tx_in_ready = ready;
  assign bus.tx_data     = data_q;
  assign bus.tx_rd       = rd;
  assign bus.tx_underrun = und_q;
  assign bus.tx_disp_err = err_q;
endmodule

// File: tb/tb_xbar_tx_frame.sv
// Directed self-checking bench for xbar_tx_frame (SYNC_WORDS=16, MIN_IDLE=6).
module tb_xbar_tx_frame;
  logic tx_clk = 1'b0;
  logic tx_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  localparam logic [39:0] IDLE_N = {10'h155, 10'h155, 10'h115, 10'h17C};
  localparam logic [39:0] IDLE_P = {10'h155, 10'h155, 10'h2D5, 10'h283};
  localparam logic [39:0] W_555  = {10'h155, 10'h155, 10'h155, 10'h155};
  localparam logic [39:0] W_17C  = {10'h155, 10'h155, 10'h155, 10'h17C};
  localparam logic [39:0] W_L1K  = {10'h155, 10'h155, 10'h17C, 10'h155};
  localparam logic [39:0] W_3FF  = {10'h155, 10'h155, 10'h155, 10'h3FF};
  localparam logic [39:0] W_283  = {10'h155, 10'h155, 10'h155, 10'h283};
  localparam logic [39:0] W_CHN  = {10'h155, 10'h155, 10'h283, 10'h17C};

  xbar_tx_frame_if bus ();

  xbar_tx_frame #(.SYNC_WORDS(16), .MIN_IDLE(6)) dut (
    .tx_clk (tx_clk),
    .tx_rst (tx_rst),
    .bus    (bus)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [39:0] d);
    bus.tx_in_valid = v;
    bus.tx_in_eof   = e;
    bus.tx_in_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0);
    tx_rst = 1'b1;
    tick();
    tick();
    tx_rst = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, W_555);
    tx_rst = 1'b1;
    tick();
    total++;
    if (bus.tx_data !== IDLE_N || bus.tx_rd !== 1'b0 || bus.tx_underrun !== 1'b0 ||
        bus.tx_disp_err !== 1'b0 || bus.tx_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: data=%h rd=%b und=%b err=%b rdy=%b",
               bus.tx_data, bus.tx_rd, bus.tx_underrun, bus.tx_disp_err, bus.tx_in_ready);
    end
    tx_rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      total++;
      if (bus.tx_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL sync_ready[%0d]: got %b want 0", k, bus.tx_in_ready);
      end
      tick();
      total++;
      if (bus.tx_data !== IDLE_N) begin
        bad++;
        $display("FAIL sync_data[%0d]: got %h want %h", k, bus.tx_data, IDLE_N);
      end
    end
    total++;
    if (bus.tx_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL sync_done_ready: got %b want 1", bus.tx_in_ready);
    end
    tick();
    total++;
    if (bus.tx_data !== W_555 || bus.tx_rd !== 1'b0) begin
      bad++;
      $display("FAIL first_data: got %h rd=%b want %h rd=0", bus.tx_data, bus.tx_rd, W_555);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_single_frame();
    do_reset();
    drive(1'b1, 1'b1, W_555);
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_555 || bus.tx_rd !== 1'b0 || bus.tx_disp_err !== 1'b0) begin
      bad++;
      $display("FAIL single_data: got %h rd=%b err=%b want %h rd=0 err=0",
               bus.tx_data, bus.tx_rd, bus.tx_disp_err, W_555);
    end
    drive(1'b1, 1'b0, W_17C);
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (bus.tx_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL gap_ready[%0d]: got %b want 0", k, bus.tx_in_ready);
      end
      tick();
      total++;
      if (bus.tx_data !== IDLE_N || bus.tx_rd !== 1'b0) begin
        bad++;
        $display("FAIL gap_data[%0d]: got %h rd=%b want %h rd=0", k, bus.tx_data, bus.tx_rd, IDLE_N);
      end
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL gap_end_ready: got %b want 1", bus.tx_in_ready);
    end
  endtask

  task automatic test_rd_flip();
    drive(1'b1, 1'b1, W_17C);
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_17C || bus.tx_rd !== 1'b1 || bus.tx_disp_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_flip_data: got %h rd=%b err=%b want %h rd=1 err=0",
               bus.tx_data, bus.tx_rd, bus.tx_disp_err, W_17C);
    end
    tick();
    total++;
    if (bus.tx_data !== IDLE_P || bus.tx_rd !== 1'b1) begin
      bad++;
      $display("FAIL rd_flip_idle: got %h rd=%b want %h rd=1", bus.tx_data, bus.tx_rd, IDLE_P);
    end
    repeat (5) tick();
  endtask

  task automatic test_underrun();
    do_reset();
    drive(1'b1, 1'b0, W_555);
    tick();
    drive(1'b0, 1'b1, W_3FF);
    total++;
    if (bus.tx_data !== W_555 || bus.tx_underrun !== 1'b0) begin
      bad++;
      $display("FAIL und_word1: got %h und=%b want %h und=0", bus.tx_data, bus.tx_underrun, W_555);
    end
    tick();
    total++;
    if (bus.tx_data !== IDLE_N || bus.tx_underrun !== 1'b1 || bus.tx_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL und_idle: got %h und=%b rdy=%b want %h und=1 rdy=1",
               bus.tx_data, bus.tx_underrun, bus.tx_in_ready, IDLE_N);
    end
    drive(1'b1, 1'b1, W_L1K);
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_L1K || bus.tx_underrun !== 1'b0 || bus.tx_rd !== 1'b1) begin
      bad++;
      $display("FAIL und_word2: got %h und=%b rd=%b want %h und=0 rd=1",
               bus.tx_data, bus.tx_underrun, bus.tx_rd, W_L1K);
    end
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (bus.tx_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL und_gap_ready[%0d]: got %b want 0", k, bus.tx_in_ready);
      end
      tick();
      total++;
      if (bus.tx_data !== IDLE_P || bus.tx_underrun !== 1'b0) begin
        bad++;
        $display("FAIL und_gap[%0d]: got %h und=%b want %h und=0", k, bus.tx_data, bus.tx_underrun, IDLE_P);
      end
    end
  endtask

  task automatic test_disp_err();
    do_reset();
    drive(1'b1, 1'b0, W_3FF);
    tick();
    total++;
    if (bus.tx_data !== W_3FF || bus.tx_disp_err !== 1'b1 || bus.tx_rd !== 1'b0) begin
      bad++;
      $display("FAIL err_3ff: got %h err=%b rd=%b want %h err=1 rd=0",
               bus.tx_data, bus.tx_disp_err, bus.tx_rd, W_3FF);
    end
    drive(1'b1, 1'b1, W_283);
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_283 || bus.tx_disp_err !== 1'b1 || bus.tx_rd !== 1'b0) begin
      bad++;
      $display("FAIL err_283_rdn: got %h err=%b rd=%b want %h err=1 rd=0",
               bus.tx_data, bus.tx_disp_err, bus.tx_rd, W_283);
    end
    tick();
    total++;
    if (bus.tx_disp_err !== 1'b0 || bus.tx_data !== IDLE_N) begin
      bad++;
      $display("FAIL err_clear: got err=%b data=%h want err=0 data=%h", bus.tx_disp_err, bus.tx_data, IDLE_N);
    end
    repeat (5) tick();
    // Lane 0 drives RD positive so lane 1's 4-one symbol is legal.
    drive(1'b1, 1'b1, W_CHN);
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_CHN || bus.tx_disp_err !== 1'b0 || bus.tx_rd !== 1'b0) begin
      bad++;
      $display("FAIL lane_chain: got %h err=%b rd=%b want %h err=0 rd=0",
               bus.tx_data, bus.tx_disp_err, bus.tx_rd, W_CHN);
    end
    repeat (6) tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 1'b0, W_17C);
    tick();
    drive(1'b1, 1'b0, W_555);
    total++;
    if (bus.tx_rd !== 1'b1 || bus.tx_data !== W_17C) begin
      bad++;
      $display("FAIL mid_pre: got %h rd=%b want %h rd=1", bus.tx_data, bus.tx_rd, W_17C);
    end
    #2;
    tx_rst = 1'b1;
    #1;
    total++;
    if (bus.tx_data !== IDLE_N || bus.tx_rd !== 1'b0 || bus.tx_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: got %h rd=%b rdy=%b want %h rd=0 rdy=0",
               bus.tx_data, bus.tx_rd, bus.tx_in_ready, IDLE_N);
    end
    tick();
    tx_rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      total++;
      if (bus.tx_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL resync_ready[%0d]: got %b want 0", k, bus.tx_in_ready);
      end
      tick();
      total++;
      if (bus.tx_data !== IDLE_N) begin
        bad++;
        $display("FAIL resync_data[%0d]: got %h want %h", k, bus.tx_data, IDLE_N);
      end
    end
    tick();
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.tx_data !== W_555 || bus.tx_rd !== 1'b0) begin
      bad++;
      $display("FAIL resync_data_out: got %h rd=%b want %h rd=0", bus.tx_data, bus.tx_rd, W_555);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_single_frame();
    test_rd_flip();
    test_underrun();
    test_disp_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
